// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared widths, requester indices and grant helper for wb_arbiter
package wb_arbiter_pkg;

  localparam int WB_REQ_NUM = 3;
  localparam int WB_REQ_EX  = 0;
  localparam int WB_REQ_LSU = 1;
  localparam int WB_REQ_MDU = 2;
  localparam int WB_AGE_W   = 4;
  localparam int REG_ADDR_W = 5;
  localparam int REG_W      = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG  = '0;
  localparam logic [REG_W-1:0]      ZERO_WORD = '0;

  typedef logic [WB_REQ_NUM-1:0] req_vec_t;
  typedef logic [WB_AGE_W-1:0]   age_t;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_W-1:0]      data;
  } wb_wr_t;

  // One-hot pick of the highest base-priority bit: EX, then LSU, then MDU.
  function automatic req_vec_t fixed_prio(input req_vec_t v);
    req_vec_t g;
    g = '0;
    if (v[WB_REQ_EX])       g[WB_REQ_EX]  = 1'b1;
    else if (v[WB_REQ_LSU]) g[WB_REQ_LSU] = 1'b1;
    else if (v[WB_REQ_MDU]) g[WB_REQ_MDU] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/wb_age_cnt.sv
// rtl/wb_age_cnt.sv - saturating wait counter with clear, present only when WB_ARB_AGING_EN is defined
`ifdef WB_ARB_AGING_EN
module wb_age_cnt
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned W = WB_AGE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - 3-way regfile write-back arbiter, fixed priority; aging promotion under WB_ARB_AGING_EN
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned AGE_LIMIT = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [WB_REQ_NUM-1:0]                  req_valid_i,
  input  logic [WB_REQ_NUM-1:0][REG_ADDR_W-1:0]  req_waddr_i,
  input  logic [WB_REQ_NUM-1:0][REG_W-1:0]       req_wdata_i,
  output logic [WB_REQ_NUM-1:0]                  req_ready_o,
  output logic                                   we_o,
  output logic [REG_ADDR_W-1:0]                  waddr_o,
  output logic [REG_W-1:0]                       wdata_o,
  output logic                                   busy_o
);

  if ((AGE_LIMIT < 1) || (AGE_LIMIT > 15)) begin : g_age_limit_out_of_range
  end

  req_vec_t grant;

`ifdef WB_ARB_AGING_EN
  localparam int unsigned AGE_LIM_C = (AGE_LIMIT < 1) ? 1 : (AGE_LIMIT > 15) ? 15 : AGE_LIMIT;
  localparam age_t        AGE_LIM   = age_t'(AGE_LIM_C);

  age_t     age [WB_REQ_NUM];
  req_vec_t promoted;

  for (genvar g = 0; g < WB_REQ_NUM; g++) begin : g_age
    wb_age_cnt #(
      .W (WB_AGE_W)
    ) u_age_cnt (
      .clk   (clk),
      .rst_n (rst),
      .inc_i (req_valid_i[g] & ~req_ready_o[g]),
      .clr_i (~req_valid_i[g] | req_ready_o[g]),
      .cnt_o (age[g])
    );
    assign promoted[g] = req_valid_i[g] && (age[g] >= AGE_LIM);
  end

  // Promoted requesters pre-empt base order; ties among them fall back to base order.
  assign grant = (|promoted) ? fixed_prio(promoted) : fixed_prio(req_valid_i);
`else
  assign grant = fixed_prio(req_valid_i);
`endif

  assign req_ready_o = rst ? grant : '0;
  assign busy_o      = rst & (|(req_valid_i & ~req_ready_o));

  wb_wr_t wr_q;
  wb_wr_t wr_d;

  // Writes to x0 are consumed but never reach the regfile.
  always_comb begin
    wr_d    = wr_q;
    wr_d.we = 1'b0;
    for (int i = 0; i < WB_REQ_NUM; i++) begin
      if (req_ready_o[i]) begin
        wr_d.we   = (req_waddr_i[i] != ZERO_REG);
        wr_d.addr = req_waddr_i[i];
        wr_d.data = req_wdata_i[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '{we: 1'b0, addr: ZERO_REG, data: ZERO_WORD};
    end else begin
      wr_q <= wr_d;
    end
  end

  assign we_o    = wr_q.we;
  assign waddr_o = wr_q.addr;
  assign wdata_o = wr_q.data;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        req_valid_i;
  logic [2:0][4:0]   req_waddr_i;
  logic [2:0][31:0]  req_wdata_i;
  logic [2:0]        req_ready_o;
  logic              we_o;
  logic [4:0]        waddr_o;
  logic [31:0]       wdata_o;
  logic              busy_o;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .AGE_LIMIT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_waddr_i (req_waddr_i),
    .req_wdata_i (req_wdata_i),
    .req_ready_o (req_ready_o),
    .we_o        (we_o),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o),
    .busy_o      (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_waddr_i[i] = a;
    req_wdata_i[i] = d;
  endtask

  initial begin
    logic [2:0] exp_rdy;

    rst         = 1'b0;
    req_valid_i = 3'b111;
    req_waddr_i = '0;
    req_wdata_i = '0;
    set_req(0, 5'd1, 32'h1);

    // reset state with requests pending
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", req_ready_o, 3'b000);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_we", we_o, 1'b0);
    chk("rst_waddr", waddr_o, 5'd0);
    chk("rst_wdata", wdata_o, 32'h0);

    @(negedge clk);
    rst = 1'b1;
    req_valid_i = 3'b000;
    #1;
    chk("idle_ready", req_ready_o, 3'b000);
    chk("idle_busy", busy_o, 1'b0);

    // single EX write
    @(negedge clk);
    set_req(0, 5'd5, 32'h12345678);
    req_valid_i = 3'b001;
    #1;
    chk("t1_ready", req_ready_o, 3'b001);
    chk("t1_busy", busy_o, 1'b0);
    chk("t1_we_pre", we_o, 1'b0);
    @(negedge clk);
    req_valid_i = 3'b000;
    #1;
    chk("t1_we", we_o, 1'b1);
    chk("t1_waddr", waddr_o, 5'd5);
    chk("t1_wdata", wdata_o, 32'h12345678);
    chk("t1_ready_off", req_ready_o, 3'b000);
    @(negedge clk);
    #1;
    chk("t1_we_drop", we_o, 1'b0);
    chk("t1_waddr_hold", waddr_o, 5'd5);

    // EX and LSU together
    @(negedge clk);
    set_req(0, 5'd3, 32'hA);
    set_req(1, 5'd4, 32'hB);
    req_valid_i = 3'b011;
    #1;
    chk("t2_c0_ready", req_ready_o, 3'b001);
    chk("t2_c0_busy", busy_o, 1'b1);
    @(negedge clk);
    req_valid_i = 3'b010;
    #1;
    chk("t2_c1_ready", req_ready_o, 3'b010);
    chk("t2_c1_busy", busy_o, 1'b0);
    chk("t2_c1_we", we_o, 1'b1);
    chk("t2_c1_waddr", waddr_o, 5'd3);
    chk("t2_c1_wdata", wdata_o, 32'hA);
    @(negedge clk);
    req_valid_i = 3'b000;
    #1;
    chk("t2_c2_we", we_o, 1'b1);
    chk("t2_c2_waddr", waddr_o, 5'd4);
    chk("t2_c2_wdata", wdata_o, 32'hB);
    @(negedge clk);
    #1;
    chk("t2_c3_we", we_o, 1'b0);

    // write to x0 is accepted but suppressed
    @(negedge clk);
    set_req(1, 5'd0, 32'hFFFFFFFF);
    req_valid_i = 3'b010;
    #1;
    chk("t3_ready", req_ready_o, 3'b010);
    @(negedge clk);
    req_valid_i = 3'b000;
    #1;
    chk("t3_we_x0", we_o, 1'b0);

    // all three at once
    @(negedge clk);
    set_req(0, 5'd1, 32'h11);
    set_req(1, 5'd2, 32'h22);
    set_req(2, 5'd3, 32'h33);
    req_valid_i = 3'b111;
    #1;
    chk("t4_c0_ready", req_ready_o, 3'b001);
    chk("t4_c0_busy", busy_o, 1'b1);
    @(negedge clk);
    req_valid_i = 3'b110;
    #1;
    chk("t4_c1_ready", req_ready_o, 3'b010);
    chk("t4_c1_busy", busy_o, 1'b1);
    chk("t4_c1_waddr", waddr_o, 5'd1);
    @(negedge clk);
    req_valid_i = 3'b100;
    #1;
    chk("t4_c2_ready", req_ready_o, 3'b100);
    chk("t4_c2_busy", busy_o, 1'b0);
    chk("t4_c2_wdata", wdata_o, 32'h22);
    @(negedge clk);
    req_valid_i = 3'b000;
    #1;
    chk("t4_c3_we", we_o, 1'b1);
    chk("t4_c3_waddr", waddr_o, 5'd3);
    chk("t4_c3_wdata", wdata_o, 32'h33);

    // EX every cycle against a waiting MDU
    @(negedge clk);
    set_req(0, 5'd6, 32'h60);
    set_req(2, 5'd7, 32'h70);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      req_valid_i = 3'b101;
      #1;
`ifdef WB_ARB_AGING_EN
      exp_rdy = (i == 4) ? 3'b100 : 3'b001;
`else
      exp_rdy = 3'b001;
`endif
      chk($sformatf("t5_c%0d_ready", i), req_ready_o, exp_rdy);
      chk($sformatf("t5_c%0d_busy", i), busy_o, 1'b1);
    end
    @(negedge clk);
    req_valid_i = 3'b000;
    #1;
    chk("t5_we", we_o, 1'b1);
`ifdef WB_ARB_AGING_EN
    chk("t5_waddr", waddr_o, 5'd7);
`else
    chk("t5_waddr", waddr_o, 5'd6);
`endif
    @(negedge clk);

    // reset right after a handshake discards the pending write
    @(negedge clk);
    set_req(0, 5'd9, 32'h99);
    req_valid_i = 3'b001;
    #1;
    chk("t6_ready", req_ready_o, 3'b001);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_we", we_o, 1'b0);
    chk("t6_rst_waddr", waddr_o, 5'd0);
    chk("t6_rst_wdata", wdata_o, 32'h0);
    chk("t6_rst_ready", req_ready_o, 3'b000);
    chk("t6_rst_busy", busy_o, 1'b0);
    @(negedge clk);
    req_valid_i = 3'b000;
    @(negedge clk);
    rst = 1'b1;
    set_req(1, 5'd8, 32'h88);
    req_valid_i = 3'b010;
    #1;
    chk("t6_rel_we", we_o, 1'b0);
    chk("t6_resume_ready", req_ready_o, 3'b010);
    @(negedge clk);
    req_valid_i = 3'b000;
    #1;
    chk("t6_resume_we", we_o, 1'b1);
    chk("t6_resume_waddr", waddr_o, 5'd8);
    chk("t6_resume_wdata", wdata_o, 32'h88);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
